// File: rtl/mod_pow4_scaler.sv
`default_nettype none
// ============================================================================
// Module      : mod_pow4_scaler
// Description : Sequential (iData * 4^iExp) mod iMod using one modular
//               quadrupler per enabled cycle, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_pow4_scaler #(
    parameter int BITWIDTH = 32,
    parameter int EXPWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iMod,
    input  logic [EXPWIDTH-1:0] iExp,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData,
    output logic                oErr,
    output logic                oBusy
);

    localparam int c_WIDE = BITWIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [BITWIDTH-1:0] r_acc;
    logic [BITWIDTH-1:0] r_mod;
    logic [EXPWIDTH-1:0] r_cnt;
    logic                r_valid;
    logic                r_err;

    logic [c_WIDE-1:0]   w_x4;
    logic [c_WIDE-1:0]   w_m1;
    logic [c_WIDE-1:0]   w_m2;
    logic [c_WIDE-1:0]   w_m3;
    logic [BITWIDTH-1:0] w_next;
    logic                w_illegal;

    // acc < M bounds the quotient of 4*acc by M below 4, so three compares suffice.
    always_comb begin
        w_x4 = {r_acc, 2'b00};
        w_m1 = {2'b00, r_mod};
        w_m2 = w_m1 << 1;
        w_m3 = w_m1 + w_m2;
        if (w_x4 >= w_m3) begin
            w_next = BITWIDTH'(w_x4 - w_m3);
        end else if (w_x4 >= w_m2) begin
            w_next = BITWIDTH'(w_x4 - w_m2);
        end else if (w_x4 >= w_m1) begin
            w_next = BITWIDTH'(w_x4 - w_m1);
        end else begin
            w_next = BITWIDTH'(w_x4);
        end
    end

    assign w_illegal = (iMod < BITWIDTH'(2)) || (iData >= iMod);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mod   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (iClr) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iValid) begin
                        r_mod <= iMod;
                        r_cnt <= iExp;
                        if (w_illegal) begin
                            r_acc   <= '0;
                            r_err   <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_acc   <= iData;
                            r_err   <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (iEn) begin
                        if (r_cnt == '0) begin
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_acc <= w_next;
                            r_cnt <= r_cnt - EXPWIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (iReady) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oReady = (r_state == S_IDLE) && !iClr;
    assign oValid = r_valid;
    assign oData  = r_acc;
    assign oErr   = r_err;
    assign oBusy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod_pow4_scaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_pow4_scaler
// Description : Self-checking bench for mod_pow4_scaler against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_pow4_scaler;

    logic        clk = 1'b0;
    logic        rst, en, clr, in_valid, in_ready;
    logic        out_ready, out_valid, out_err, busy;
    logic [31:0] in_data, in_mod, out_data;
    logic [7:0]  in_exp;

    int n_pass  = 0;
    int n_total = 0;

    mod_pow4_scaler #(.BITWIDTH(32), .EXPWIDTH(8)) dut (
        .iClk  (clk),
        .iRst  (rst),
        .iEn   (en),
        .iClr  (clr),
        .iValid(in_valid),
        .oReady(out_ready),
        .iData (in_data),
        .iMod  (in_mod),
        .iExp  (in_exp),
        .oValid(out_valid),
        .iReady(in_ready),
        .oData (out_data),
        .oErr  (out_err),
        .oBusy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_val(input longint d, input longint m, input int e);
        longint r;
        if (m < 2 || d >= m) return 32'd0;
        r = d;
        for (int i = 0; i < e; i++) r = (r * 4) % m;
        return r[31:0];
    endfunction

    function automatic logic model_err(input longint d, input longint m);
        return (m < 2 || d >= m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge, then scrambles the inputs.
    task automatic send(input logic [31:0] d, input logic [31:0] m, input logic [7:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_mod   = m;
        in_exp   = e;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_mod   = $urandom;
        in_exp   = 8'($urandom);
    endtask

    task automatic wait_valid(input int budget, input bit rand_en, output int en_edges);
        int  t;
        bit  en_now;
        t        = 0;
        en_edges = 0;
        while (out_valid !== 1'b1 && t < budget) begin
            if (rand_en) en = ($urandom_range(0, 2) != 0);
            en_now = en;
            tick();
            t++;
            if (en_now) en_edges++;
        end
        if (out_valid !== 1'b1) begin
            n_total++;
            $display("FAIL wait_valid_timeout: oValid=%b after %0d cycles, required 1", out_valid, t);
        end
        en = 1'b1;
    endtask

    task automatic consume();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({out_valid, out_err, busy, out_data} !== {1'b0, 1'b0, 1'b0, 32'd0})
            $display("FAIL reset_outputs: valid=%b err=%b busy=%b data=%0d, required 0/0/0/0",
                     out_valid, out_err, busy, out_data);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (out_ready !== 1'b1) $display("FAIL reset_ready: oReady=%b required 1", out_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int c;
        send(32'd5, 32'd23, 8'd3);
        wait_valid(50, 1'b0, c);
        n_total++;
        if (c !== 4) $display("FAIL basic_latency: %0d edges, required 4", c);
        else n_pass++;
        n_total++;
        if (out_data !== model_val(5, 23, 3) || out_err !== 1'b0)
            $display("FAIL basic_data: data=%0d err=%b, required %0d/0", out_data, out_err, model_val(5, 23, 3));
        else n_pass++;
        consume();
        n_total++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1)
            $display("FAIL basic_consume: valid=%b ready=%b, required 0/1", out_valid, out_ready);
        else n_pass++;
    endtask

    task automatic test_zero_exp_backpressure();
        int c;
        send(32'd7, 32'd23, 8'd0);
        wait_valid(50, 1'b0, c);
        n_total++;
        if (c !== 1 || out_data !== 32'd7)
            $display("FAIL zero_exp: edges=%0d data=%0d, required 1/7", c, out_data);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 32'd7 || out_ready !== 1'b0)
                $display("FAIL backpressure_hold: valid=%b data=%0d ready=%b, required 1/7/0",
                         out_valid, out_data, out_ready);
            else n_pass++;
        end
        consume();
    endtask

    task automatic test_stall();
        int c;
        send(32'd22, 32'd23, 8'd1);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL stall_hold: valid=%b busy=%b, required 0/1", out_valid, busy);
            else n_pass++;
        end
        en = 1'b1;
        wait_valid(50, 1'b0, c);
        n_total++;
        if (c !== 1 || out_data !== 32'd19)
            $display("FAIL stall_result: edges=%0d data=%0d, required 1/19", c, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_errors();
        int c;
        send(32'd0, 32'd1, 8'd5);
        wait_valid(5, 1'b0, c);
        n_total++;
        if (c !== 0 || out_err !== 1'b1 || out_data !== 32'd0)
            $display("FAIL err_mod1: edges=%0d err=%b data=%0d, required 0/1/0", c, out_err, out_data);
        else n_pass++;
        consume();
        send(32'd30, 32'd23, 8'd2);
        wait_valid(5, 1'b0, c);
        n_total++;
        if (c !== 0 || out_err !== model_err(30, 23) || out_data !== 32'd0)
            $display("FAIL err_data_ge_mod: edges=%0d err=%b data=%0d, required 0/1/0", c, out_err, out_data);
        else n_pass++;
        consume();
    endtask

    task automatic test_abort();
        int c;
        send(32'd1, 32'd23, 8'd10);
        tick();
        tick();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd4;
        in_mod   = 32'd23;
        in_exp   = 8'd1;
        tick();
        n_total++;
        if (out_ready !== 1'b0) $display("FAIL clr_blocks_ready: oReady=%b required 0", out_ready);
        else n_pass++;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_ready !== 1'b1 || out_err !== 1'b0)
            $display("FAIL abort_idle: valid=%b busy=%b ready=%b err=%b, required 0/0/1/0",
                     out_valid, busy, out_ready, out_err);
        else n_pass++;
        send(32'd3, 32'd23, 8'd2);
        wait_valid(50, 1'b0, c);
        n_total++;
        if (c !== 3 || out_data !== model_val(3, 23, 2))
            $display("FAIL after_abort: edges=%0d data=%0d, required 3/%0d", c, out_data, model_val(3, 23, 2));
        else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid_run();
        send(32'd5, 32'd23, 8'd8);
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if ({out_valid, out_err, busy, out_data} !== {1'b0, 1'b0, 1'b0, 32'd0})
            $display("FAIL reset_mid_run: valid=%b err=%b busy=%b data=%0d, required 0/0/0/0",
                     out_valid, out_err, busy, out_data);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int c, hold, results;
        logic [31:0] d, expv;
        logic [7:0]  e;
        results = 0;
        for (int k = 0; k < 100; k++) begin
            d    = $urandom_range(0, 22);
            e    = 8'($urandom_range(0, 15));
            expv = model_val(d, 23, e);
            en   = $urandom_range(0, 1);
            send(d, 32'd23, e);
            wait_valid(200, 1'b1, c);
            n_total++;
            if (c !== int'(e) + 1 || out_data !== expv || out_err !== 1'b0)
                $display("FAIL random_result[%0d]: d=%0d e=%0d edges=%0d data=%0d err=%b, required %0d/%0d/0",
                         k, d, e, c, out_data, out_err, int'(e) + 1, expv);
            else n_pass++;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                n_total++;
                if (out_valid !== 1'b1 || out_data !== expv)
                    $display("FAIL random_hold[%0d]: valid=%b data=%0d, required 1/%0d", k, out_valid, out_data, expv);
                else n_pass++;
            end
            consume();
            results++;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL random_consume[%0d]: oValid=%b required 0", k, out_valid);
            else n_pass++;
        end
        n_total++;
        if (results !== 100) $display("FAIL random_count: %0d results, required 100", results);
        else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_data  = '0;
        in_mod   = '0;
        in_exp   = '0;
        test_reset();
        test_basic();
        test_zero_exp_backpressure();
        test_stall();
        test_errors();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
